// File: rtl/echo_ctrl.sv
// echo_ctrl: sequences configuration updates into the echo datapath.
// A decay-only change is applied on the next sample tick, while a delay
// change is wrapped in a muted fade-out / apply / fade-in sequence so the
// delay line jump is never heard.
// Optional feature: define ECHO_CTRL_CLAMP_EN to clamp captured delays to
// DELAY_MAX; without it the requested delay is stored unmodified.
module echo_ctrl #(
   parameter int DELAY_MAX  = 48000,
   parameter int MUTE_TICKS = 4
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        run_in,
   input  logic        tick_in,
   input  logic        cfg_valid_in,
   output logic        cfg_ready_out,
   input  logic [15:0] cfg_delay_in,
   input  logic [15:0] cfg_decay_in,
   output logic        enable_out,
   output logic [15:0] delay_out,
   output logic [15:0] decay_out,
   output logic        mute_out,
   output logic        busy_out
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      FADE_OUT = 3'd2,
      APPLY    = 3'd3,
      FADE_IN  = 3'd4
   } state_t;

`ifdef ECHO_CTRL_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   localparam logic [15:0] DMAX      = 16'(DELAY_MAX);
   localparam logic [7:0]  LAST_TICK = 8'(MUTE_TICKS - 1);

   state_t      state;
   state_t      state_next;
   logic [7:0]  tick_cnt;
   logic [15:0] pend_delay;
   logic [15:0] pend_decay;
   logic        pend_now;
   logic        pend_tick;
   logic        accept;
   logic        last_tick;
   logic        delay_change;
   logic [15:0] captured_delay;
   logic [15:0] cur_delay;

   assign accept         = cfg_valid_in && cfg_ready_out;
   assign last_tick      = tick_in && (tick_cnt == LAST_TICK);
   assign captured_delay = (CLAMP_EN && (cfg_delay_in > DMAX)) ? DMAX : cfg_delay_in;
   // An IDLE-accepted config still waiting to land is the delay that counts.
   assign cur_delay      = pend_now ? pend_delay : delay_out;
   assign delay_change   = accept && (state == RUN) && (captured_delay != cur_delay);

   // State register; reset wins over every other input on the edge.
   always_ff @(posedge clk) begin
      if (srst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; dropping run_in always returns to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (run_in) state_next = RUN;
         end
         RUN: begin
            if (!run_in)           state_next = IDLE;
            else if (delay_change) state_next = FADE_OUT;
         end
         FADE_OUT: begin
            if (!run_in)        state_next = IDLE;
            else if (last_tick) state_next = APPLY;
         end
         APPLY: begin
            if (!run_in) state_next = IDLE;
            else         state_next = FADE_IN;
         end
         FADE_IN: begin
            if (!run_in)        state_next = IDLE;
            else if (last_tick) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   // Status outputs are pure functions of state so the handshake never
   // depends combinationally on cfg_valid_in.
   always_comb begin
      enable_out    = 1'b0;
      mute_out      = 1'b0;
      busy_out      = 1'b0;
      cfg_ready_out = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready_out = 1'b1;
         end
         RUN: begin
            enable_out    = 1'b1;
            cfg_ready_out = 1'b1;
         end
         FADE_OUT, FADE_IN: begin
            enable_out = 1'b1;
            mute_out   = 1'b1;
            busy_out   = 1'b1;
         end
         APPLY: begin
            mute_out = 1'b1;
            busy_out = 1'b1;
         end
         default: begin
            cfg_ready_out = 1'b0;
         end
      endcase
   end

   // Pending capture and output register updates; a newly accepted config
   // replaces any decay-only update that has not yet reached a tick.
   always_ff @(posedge clk) begin
      if (srst) begin
         delay_out  <= 16'd0;
         decay_out  <= 16'd0;
         pend_delay <= 16'd0;
         pend_decay <= 16'd0;
         pend_now   <= 1'b0;
         pend_tick  <= 1'b0;
      end else begin
         if (pend_now) begin
            delay_out <= pend_delay;
            decay_out <= pend_decay;
            pend_now  <= 1'b0;
         end
         case (state)
            RUN: begin
               if (!run_in) begin
                  if (pend_tick) decay_out <= pend_decay;
                  pend_tick <= 1'b0;
               end else if (tick_in && pend_tick && !accept) begin
                  decay_out <= pend_decay;
                  pend_tick <= 1'b0;
               end
            end
            FADE_OUT, FADE_IN: begin
               if (!run_in) begin
                  delay_out <= pend_delay;
                  decay_out <= pend_decay;
               end
            end
            APPLY: begin
               delay_out <= pend_delay;
               decay_out <= pend_decay;
            end
            default: begin
            end
         endcase
         if (accept) begin
            pend_delay <= captured_delay;
            pend_decay <= cfg_decay_in;
            if ((state == IDLE) || !run_in) begin
               pend_now  <= 1'b1;
               pend_tick <= 1'b0;
            end else begin
               pend_tick <= !delay_change;
            end
         end
      end
   end

   // Fade tick counter, cleared whenever a new state is entered.
   always_ff @(posedge clk) begin
      if (srst) begin
         tick_cnt <= 8'd0;
      end else if (state_next != state) begin
         tick_cnt <= 8'd0;
      end else if (tick_in && ((state == FADE_OUT) || (state == FADE_IN))) begin
         tick_cnt <= tick_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_echo_ctrl.sv
// tb_echo_ctrl: directed scenarios plus randomized traffic for echo_ctrl,
// checked every cycle against a phase/countdown model of the controller.
module tb_echo_ctrl;

   localparam int DELAY_MAX  = 48000;
   localparam int MUTE_TICKS = 4;

   localparam int P_IDLE     = 0;
   localparam int P_RUN      = 1;
   localparam int P_FADE_OUT = 2;
   localparam int P_APPLY    = 3;
   localparam int P_FADE_IN  = 4;

   logic        clk;
   logic        srst;
   logic        run_in;
   logic        tick_in;
   logic        cfg_valid_in;
   logic        cfg_ready_out;
   logic [15:0] cfg_delay_in;
   logic [15:0] cfg_decay_in;
   logic        enable_out;
   logic [15:0] delay_out;
   logic [15:0] decay_out;
   logic        mute_out;
   logic        busy_out;

   int errCount   = 0;
   int checkCount = 0;
   bit cmpEn      = 1'b0;

   // model state: phase, ticks still owed, outputs and pending request
   int          mPhase;
   int          mRemain;
   logic [15:0] mDelay;
   logic [15:0] mDecay;
   logic [15:0] pDelay;
   logic [15:0] pDecay;
   bit          loadNext;
   bit          tickUpd;

   echo_ctrl #(
      .DELAY_MAX (DELAY_MAX),
      .MUTE_TICKS(MUTE_TICKS)
   ) dut (
      .clk          (clk),
      .srst         (srst),
      .run_in       (run_in),
      .tick_in      (tick_in),
      .cfg_valid_in (cfg_valid_in),
      .cfg_ready_out(cfg_ready_out),
      .cfg_delay_in (cfg_delay_in),
      .cfg_decay_in (cfg_decay_in),
      .enable_out   (enable_out),
      .delay_out    (delay_out),
      .decay_out    (decay_out),
      .mute_out     (mute_out),
      .busy_out     (busy_out)
   );

   // free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] clampDelay(input logic [15:0] d);
`ifdef ECHO_CTRL_CLAMP_EN
      return (d > 16'(DELAY_MAX)) ? 16'(DELAY_MAX) : d;
`else
      return d;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // drive one cycle of inputs, advance the model across the edge
   task automatic applyStimulus(input bit r, input bit run, input bit tk, input bit vld,
                                input logic [15:0] dly, input logic [15:0] dcy);
      int          nPhase;
      int          nRemain;
      logic [15:0] nDelay, nDecay, nPD, nPDc, cd, eff;
      bit          nLoad, nTick, ready, acc;
      srst         = r;
      run_in       = run;
      tick_in      = tk;
      cfg_valid_in = vld;
      cfg_delay_in = dly;
      cfg_decay_in = dcy;
      nPhase = mPhase; nRemain = mRemain; nDelay = mDelay; nDecay = mDecay;
      nPD = pDelay; nPDc = pDecay; nLoad = loadNext; nTick = tickUpd;
      ready = (mPhase == P_IDLE) || (mPhase == P_RUN);
      acc   = vld && ready;
      cd    = clampDelay(dly);
      if (r) begin
         nPhase = P_IDLE; nRemain = 0; nDelay = 0; nDecay = 0;
         nPD = 0; nPDc = 0; nLoad = 0; nTick = 0;
      end else begin
         if (loadNext) begin
            nDelay = pDelay; nDecay = pDecay; nLoad = 0;
         end
         if (mPhase == P_IDLE) begin
            if (run) nPhase = P_RUN;
         end else if (mPhase == P_RUN) begin
            eff = loadNext ? pDelay : mDelay;
            if (!run) begin
               if (tickUpd) nDecay = pDecay;
               nTick  = 0;
               nPhase = P_IDLE;
            end else if (acc && cd != eff) begin
               nPhase = P_FADE_OUT; nRemain = MUTE_TICKS; nTick = 0;
            end else if (acc) begin
               nTick = 1;
            end else if (tk && tickUpd) begin
               nDecay = pDecay; nTick = 0;
            end
         end else if (mPhase == P_APPLY) begin
            nDelay = pDelay; nDecay = pDecay;
            if (!run) nPhase = P_IDLE;
            else begin nPhase = P_FADE_IN; nRemain = MUTE_TICKS; end
         end else begin
            if (!run) begin
               nDelay = pDelay; nDecay = pDecay; nPhase = P_IDLE;
            end else if (tk) begin
               nRemain = mRemain - 1;
               if (nRemain == 0) nPhase = (mPhase == P_FADE_OUT) ? P_APPLY : P_RUN;
            end
         end
         if (acc) begin
            nPD = cd; nPDc = dcy;
            if (mPhase == P_IDLE || !run) begin nLoad = 1; nTick = 0; end
         end
      end
      @(posedge clk);
      mPhase = nPhase; mRemain = nRemain; mDelay = nDelay; mDecay = nDecay;
      pDelay = nPD; pDecay = nPDc; loadNext = nLoad; tickUpd = nTick;
      #1;
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (cmpEn) begin
         checkOutput("enable", 16'(enable_out), 16'(mPhase == P_RUN || mPhase == P_FADE_OUT || mPhase == P_FADE_IN));
         checkOutput("mute", 16'(mute_out), 16'(mPhase >= P_FADE_OUT));
         checkOutput("busy", 16'(busy_out), 16'(mPhase >= P_FADE_OUT));
         checkOutput("ready", 16'(cfg_ready_out), 16'(mPhase <= P_RUN));
         checkOutput("delay", delay_out, mDelay);
         checkOutput("decay", decay_out, mDecay);
      end
   end

   initial begin
      int enZero;
      int readyHigh;
      int sel;
      logic [15:0] d;
      logic [15:0] clampExp;
      mPhase = P_IDLE; mRemain = 0; mDelay = 0; mDecay = 0;
      pDelay = 0; pDecay = 0; loadNext = 0; tickUpd = 0;

      applyStimulus(1, 0, 0, 0, 0, 0);
      cmpEn = 1'b1;
      applyStimulus(1, 1, 1, 1, 16'd7, 16'd7);
      checkOutput("rst_ready", 16'(cfg_ready_out), 16'd1);
      checkOutput("rst_delay", delay_out, 16'd0);
      checkOutput("rst_enable", 16'(enable_out), 16'd0);

      // IDLE configuration lands one cycle after acceptance
      applyStimulus(0, 0, 0, 1, 16'd1000, 16'h4000);
      checkOutput("idle_delay_early", delay_out, 16'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_delay", delay_out, 16'd1000);
      checkOutput("idle_decay", decay_out, 16'h4000);
      checkOutput("idle_enable", 16'(enable_out), 16'd0);

      // decay-only change in RUN waits for a tick, no mute
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("run_enable", 16'(enable_out), 16'd1);
      applyStimulus(0, 1, 0, 1, 16'd1000, 16'h2000);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("decay_wait", decay_out, 16'h4000);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("decay_tick", decay_out, 16'h2000);
      checkOutput("decay_mute", 16'(mute_out), 16'd0);

      // delay change: full fade sequence
      applyStimulus(0, 1, 0, 1, 16'd2000, 16'h1000);
      checkOutput("fade_mute", 16'(mute_out), 16'd1);
      checkOutput("fade_delay_hold", delay_out, 16'd1000);
      enZero = 0;
      readyHigh = 0;
      for (int k = 0; k < 16; k++) begin
         applyStimulus(0, 1, bit'(k % 2), 0, 0, 0);
         if (!enable_out) enZero++;
         if (k < 15 && cfg_ready_out) readyHigh++;
         if (k == 8) checkOutput("fade_in_delay", delay_out, 16'd2000);
      end
      checkOutput("fade_en_zero", 16'(enZero), 16'd1);
      checkOutput("fade_ready_low", 16'(readyHigh), 16'd0);
      checkOutput("fade_done_mute", 16'(mute_out), 16'd0);
      checkOutput("fade_done_decay", decay_out, 16'h1000);

      // abort during FADE_OUT loads the pending config
      applyStimulus(0, 1, 0, 1, 16'd3000, 16'h0800);
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("abort_delay", delay_out, 16'd3000);
      checkOutput("abort_mute", 16'(mute_out), 16'd0);
      checkOutput("abort_busy", 16'(busy_out), 16'd0);

      // over-range delay
`ifdef ECHO_CTRL_CLAMP_EN
      clampExp = 16'd48000;
`else
      clampExp = 16'd60000;
`endif
      applyStimulus(0, 0, 0, 1, 16'd60000, 16'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("clamp_delay", delay_out, clampExp);

      // reset in FADE_IN
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 16'd100, 16'h0100);
      for (int k = 0; k < 5; k++) applyStimulus(0, 1, bit'(k < 4), 0, 0, 0);
      checkOutput("fadein_mute", 16'(mute_out), 16'd1);
      checkOutput("fadein_delay", delay_out, 16'd100);
      applyStimulus(1, 1, 1, 1, 16'd5, 16'd5);
      checkOutput("srst_delay", delay_out, 16'd0);
      checkOutput("srst_mute", 16'(mute_out), 16'd0);
      checkOutput("srst_enable", 16'(enable_out), 16'd0);
      checkOutput("srst_ready", 16'(cfg_ready_out), 16'd1);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0: d = 16'd0;
            1: d = 16'd1000;
            2: d = 16'd2000;
            3: d = 16'd60000;
            4: d = mDelay;
            default: d = 16'($urandom);
         endcase
         applyStimulus(bit'($urandom_range(0, 599) == 0),
                       bit'($urandom_range(0, 39) != 0),
                       bit'($urandom_range(0, 2) == 0),
                       bit'($urandom_range(0, 7) == 0),
                       d, 16'($urandom));
      end

      cmpEn = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/echo_ctrl.md
ECHO_CTRL -- requirements
Module: echo_ctrl

Interface
REQ-001 Parameter DELAY_MAX, default 48000, largest legal delay value in samples (1..65535).
REQ-002 Parameter MUTE_TICKS, default 4, tick_in pulses spent muted before and after a delay change (>=1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 srst  input  1  synchronous, active-high reset.
REQ-005 run_in  input  1  level; 1 = echo running, 0 = echo bypassed/idle.
REQ-006 tick_in  input  1  one-cycle sample strobe from the echo datapath tick_out.
REQ-007 cfg_valid_in  input  1  host configuration request valid.
REQ-008 cfg_ready_out  output  1  controller can accept a configuration.
REQ-009 cfg_delay_in  input  16  requested delay (samples).
REQ-010 cfg_decay_in  input  16  requested decay coefficient.
REQ-011 enable_out  output  1  drives echo enable_in.
REQ-012 delay_out  output  16  drives echo delay_in.
REQ-013 decay_out  output  16  drives echo decay_in.
REQ-014 mute_out  output  1  1 while a delay change is in progress; downstream mutes audio.
REQ-015 busy_out  output  1  1 in any state other than IDLE and RUN.

Function
REQ-016 FSM states: IDLE, RUN, FADE_OUT, APPLY, FADE_IN.
REQ-017 Handshake: config accepted on a clk edge with cfg_valid_in=1 and cfg_ready_out=1; request fields captured into pending registers on that edge.
REQ-018 cfg_ready_out = 1 only in IDLE and RUN; registered/derived from state, never combinationally from cfg_valid_in.
REQ-019 IDLE: enable_out=0; accepted config written to delay_out/decay_out on the next edge; run_in=1 -> RUN next cycle.
REQ-020 RUN: enable_out=1; accepted config with delay equal to delay_out updates decay_out on the first tick_in cycle after acceptance, no mute.
REQ-021 RUN: accepted config with delay different from delay_out -> FADE_OUT, mute_out=1 from next cycle.
REQ-022 FADE_OUT: count MUTE_TICKS tick_in pulses; on the cycle of the last pulse -> APPLY.
REQ-023 APPLY: exactly one cycle; enable_out=0; delay_out and decay_out loaded from pending; -> FADE_IN.
REQ-024 FADE_IN: enable_out=1, mute_out=1; count MUTE_TICKS tick_in pulses; on the last -> RUN, mute_out=0 next cycle.
REQ-025 Tick counter 8-bit, cleared on every state entry; tick_in during APPLY ignored.
REQ-026 run_in=0 in RUN -> IDLE next cycle; any pending decay-only update is applied on that transition.
REQ-027 run_in=0 in FADE_OUT/FADE_IN/APPLY -> abort: pending config loaded immediately, mute_out=0, -> IDLE next cycle.
REQ-028 cfg_valid_in while cfg_ready_out=0 is held off; no loss, no overwrite of pending.
REQ-029 Second config accepted in RUN before a pending decay-only update applies replaces the pending one (last wins).
REQ-030 delay 0 is legal and passed through unchanged.

Reset
REQ-031 srst=1: state IDLE, enable_out=0, mute_out=0, busy_out=0, cfg_ready_out=1 after the reset edge, delay_out=0, decay_out=0, pending registers and tick counter 0.
REQ-032 srst mid-sequence (any state) takes priority over all inputs on that edge; no pending update is applied.

Configuration
REQ-033 Macro ECHO_CTRL_CLAMP_EN defined: captured cfg_delay_in > DELAY_MAX is stored as DELAY_MAX.
REQ-034 ECHO_CTRL_CLAMP_EN undefined: cfg_delay_in stored unmodified; port list identical in both builds.

Verification
REQ-035 Reset, then cfg delay=1000 decay=0x4000 in IDLE -> delay_out=1000, decay_out=0x4000 one cycle later, enable_out=0.
REQ-036 RUN, delay=1000, cfg delay=1000 decay=0x2000 -> decay_out=0x2000 on first tick, mute_out never 1, busy_out 0.
REQ-037 RUN, cfg delay=2000, MUTE_TICKS=4 -> mute_out 1 for 4+4 ticks, enable_out 0 exactly one cycle, delay_out=2000 after APPLY, cfg_ready_out 0 throughout.
REQ-038 run_in=0 after 2 ticks of FADE_OUT with delay=3000 pending -> IDLE next cycle, delay_out=3000, mute_out=0.
REQ-039 cfg delay=60000, DELAY_MAX=48000 -> delay_out=48000 with ECHO_CTRL_CLAMP_EN, 60000 without.
REQ-040 srst asserted in FADE_IN -> all outputs at reset values next cycle; cfg_ready_out=1.
